// File: rtl/dmem_if.sv
// Load/store handshake between the memory stage (master) and the data-memory
// responder (slave).
//   Req_ME    request strobe, held with its fields while Stall_DM is high
//   Write_ME  1 = store, 0 = load
//   Byte_ME   1 = byte access, 0 = word access
//   Adr_ME    byte address
//   WrDat_ME  store data (byte stores use bits [7:0])
//   Stall_DM  responder busy, holds the pipeline
//   Ack_DM    one-cycle completion pulse
//   RdDat_DM  load data, valid with Ack_DM
interface dmem_if;
  logic        Req_ME;
  logic        Write_ME;
  logic        Byte_ME;
  logic [31:0] Adr_ME;
  logic [31:0] WrDat_ME;
  logic        Stall_DM;
  logic        Ack_DM;
  logic [31:0] RdDat_DM;

  modport master (
    output Req_ME, Write_ME, Byte_ME, Adr_ME, WrDat_ME,
    input  Stall_DM, Ack_DM, RdDat_DM
  );

  modport slave (
    input  Req_ME, Write_ME, Byte_ME, Adr_ME, WrDat_ME,
    output Stall_DM, Ack_DM, RdDat_DM
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with a 2**ADDR_W x 32 word RAM.
// One load/store is accepted at a time; Stall_DM holds the pipeline for
// LATENCY cycles, then Ack_DM pulses for one cycle with load data on RdDat_DM.
// Byte stores update only the addressed lane; byte loads are zero-extended.
// Ports:
//   clk         clock, all state on posedge
//   flush       synchronous active-high reset (RAM contents are kept)
//   bus         dmem_if.slave load/store handshake
//   StallCnt_DM 16-bit count of stalled cycles, only when DMEM_STALL_COUNT_EN
//               is defined
module dmem_responder #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 6
) (
  input  logic        clk,
  input  logic        flush,
  dmem_if.slave       bus
`ifdef DMEM_STALL_COUNT_EN
  ,
  output logic [15:0] StallCnt_DM
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, nextState;

  logic [3:0]        cnt;
  logic              wrQ, byteQ;
  logic [ADDR_W-1:0] idxQ;
  logic [1:0]        laneQ;
  logic [31:0]       wdatQ;
  logic              ackQ;
  logic [31:0]       rdQ;

  logic [31:0] mem [2**ADDR_W];

  logic              stall, accept, access;
  logic              opWr, opByte;
  logic [ADDR_W-1:0] opIdx;
  logic [1:0]        opLane;
  logic [31:0]       opDat;

  // Address bits above the word index never reach the RAM.
  logic unusedAdr;
  assign unusedAdr = ^bus.Adr_ME[31:ADDR_W+2];

  always_ff @(posedge clk) begin
    if (flush) state <= IDLE;
    else       state <= nextState;
  end

  // Cnt is loaded with LATENCY-1 and the access fires on the BUSY edge where
  // it reaches 1, so the pipeline sees exactly LATENCY stall cycles (accept
  // cycle plus LATENCY-1 BUSY cycles). With LATENCY=1 there is no BUSY cycle
  // and the access uses the live request fields on the accept edge.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    opWr      = wrQ;
    opByte    = byteQ;
    opIdx     = idxQ;
    opLane    = laneQ;
    opDat     = wdatQ;
    case (state)
      IDLE: begin
        stall = bus.Req_ME;
        if (bus.Req_ME) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            access    = 1'b1;
            nextState = DONE;
            opWr      = bus.Write_ME;
            opByte    = bus.Byte_ME;
            opIdx     = bus.Adr_ME[ADDR_W+1:2];
            opLane    = bus.Adr_ME[1:0];
            opDat     = bus.WrDat_ME;
          end else begin
            nextState = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd1) begin
          access    = 1'b1;
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    // flush wins over everything on the same edge, including the RAM write.
    if (flush) begin
      nextState = IDLE;
      accept    = 1'b0;
      access    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      cnt   <= '0;
      wrQ   <= 1'b0;
      byteQ <= 1'b0;
      idxQ  <= '0;
      laneQ <= '0;
      wdatQ <= '0;
      ackQ  <= 1'b0;
      rdQ   <= '0;
    end else begin
      ackQ <= access;
      if (accept) begin
        wrQ   <= bus.Write_ME;
        byteQ <= bus.Byte_ME;
        idxQ  <= bus.Adr_ME[ADDR_W+1:2];
        laneQ <= bus.Adr_ME[1:0];
        wdatQ <= bus.WrDat_ME;
        cnt   <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !opWr) begin
        if (opByte) rdQ <= {24'b0, mem[opIdx][{opLane, 3'b000} +: 8]};
        else        rdQ <= mem[opIdx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access && opWr) begin
      if (opByte) mem[opIdx][{opLane, 3'b000} +: 8] <= opDat[7:0];
      else        mem[opIdx] <= opDat;
    end
  end

`ifdef DMEM_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (flush)      StallCnt_DM <= '0;
    else if (stall) StallCnt_DM <= StallCnt_DM + 16'd1;
  end
`endif

  assign bus.Stall_DM = stall;
  assign bus.Ack_DM   = ackQ;
  assign bus.RdDat_DM = rdQ;

endmodule
